// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares one physical memory port between instruction fetch (I)
// and data (D) requesters. The winning request is registered, held until the
// memory completes, then answered with a one-cycle response.
// Default build: fixed D priority with a starvation counter for I.
// Optional macro LC3B_ARB_RR_EN: round-robin arbitration instead, no starvation counter.
module lc3b_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [1:0]        dmem_wmask,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [1:0]        pmem_wmask,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {StIdle, StServI, StServD, StResp} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_win_d;   // 1: current transaction belongs to D
  logic                r_wr;      // 1: latched op is a write
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_wmask;
  logic [DATA_W-1:0]   r_irdata;
  logic [DATA_W-1:0]   r_drdata;

  logic w_i_pend;
  logic w_d_pend;
  logic w_arb_d;
  logic w_arb_i;
  logic w_grant_d;
  logic w_grant_i;

  assign w_i_pend  = imem_read;
  assign w_d_pend  = dmem_read | dmem_write;
  assign w_arb_i   = w_i_pend & ~w_arb_d;
  assign w_grant_d = (r_state == StIdle) & w_arb_d;
  assign w_grant_i = (r_state == StIdle) & w_arb_i;

`ifdef LC3B_ARB_RR_EN
  logic r_last_d;  // 1: D was granted last; resets to I so D wins the first tie

  // On a tie the requester not granted last wins
  always_comb begin
    w_arb_d = w_d_pend & (~w_i_pend | ~r_last_d);
  end

  // Remember the most recent winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] r_starve_cnt;
  logic            w_starved;

  assign w_starved = (r_starve_cnt == CntW'(STARVE_MAX));

  // D wins unless I is waiting and has been passed over STARVE_MAX times
  always_comb begin
    w_arb_d = w_d_pend & ~(w_i_pend & w_starved);
  end

  // Count consecutive D grants while I waits; saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d) begin
      if (!w_i_pend) begin
        r_starve_cnt <= '0;
      end else if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state: arbitrate in idle, wait for memory, one response cycle
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant_d) begin
          w_state_d = StServD;
        end else if (w_grant_i) begin
          w_state_d = StServI;
        end
      end
      StServI, StServD: begin
        if (pmem_resp) begin
          w_state_d = StResp;
        end
      end
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Latch the winning request on grant; capture read data on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_d  <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wmask  <= 2'b00;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      if (w_grant_d) begin
        r_win_d <= 1'b1;
        r_wr    <= dmem_write;  // read+write together executes as a write
        r_addr  <= dmem_address;
        r_wdata <= dmem_wdata;
        r_wmask <= dmem_wmask;
      end else if (w_grant_i) begin
        r_win_d <= 1'b0;
        r_wr    <= 1'b0;
        r_addr  <= imem_address;
        r_wdata <= '0;
        r_wmask <= 2'b00;
      end
      if (pmem_resp && (r_state == StServI)) begin
        r_irdata <= pmem_rdata;
      end
      if (pmem_resp && (r_state == StServD)) begin
        r_drdata <= pmem_rdata;
      end
    end
  end

  // Outputs come from registered state only
  assign pmem_read    = (r_state == StServI) | ((r_state == StServD) & ~r_wr);
  assign pmem_write   = (r_state == StServD) & r_wr;
  assign pmem_wmask   = r_wmask;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign imem_resp    = (r_state == StResp) & ~r_win_d;
  assign dmem_resp    = (r_state == StResp) & r_win_d;
  assign imem_rdata   = r_irdata;
  assign dmem_rdata   = r_drdata;

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Shares the single physical memory port between two requesters: the instruction-fetch side (I, read-only) and the data side (D, LDR/STR and similar).
- Sits between the fetch and memory stages and the physical memory model.
- Arbitrates, registers the winning request, holds it stable until the memory completes, then returns a one-cycle response to the winner.
- Fixed priority gives D precedence. A starvation counter guarantees I forward progress.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- STARVE_MAX, 4, number of consecutive D grants while I waits, after which I is forced next (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_read  in  1  I read request; held until imem_resp.
- imem_address  in  ADDR_W  I address.
- imem_rdata  out  DATA_W  I read data; valid when imem_resp=1.
- imem_resp  out  1  one-cycle I completion pulse.
- dmem_read  in  1  D read request; held until dmem_resp.
- dmem_write  in  1  D write request; held until dmem_resp.
- dmem_wmask  in  2  D byte enables ([0] low byte, [1] high byte).
- dmem_address  in  ADDR_W  D address.
- dmem_wdata  in  DATA_W  D write data.
- dmem_rdata  out  DATA_W  D read data; valid when dmem_resp=1.
- dmem_resp  out  1  one-cycle D completion pulse.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_wmask  out  2  physical byte enables.
- pmem_address  out  ADDR_W  physical address.
- pmem_wdata  out  DATA_W  physical write data.
- pmem_rdata  in  DATA_W  physical read data; valid with pmem_resp.
- pmem_resp  in  1  physical completion, one cycle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; starve_cnt=0.
  - All outputs are 0, including rdata registers.
  - A transaction in flight is abandoned. The memory side must tolerate the strobe dropping.
- States: IDLE, SERV_I, SERV_D, RESP.
- IDLE: arbitrate on the current request inputs; the result registers on the next edge.
  - D pending (dmem_read|dmem_write) and not starved: go to SERV_D.
  - I pending (imem_read) and starved (starve_cnt==STARVE_MAX): go to SERV_I.
  - I pending only: go to SERV_I.
  - Nothing pending: stay in IDLE.
- On grant, latch address, wdata, wmask and op into internal registers.
  - pmem_* outputs are driven only from these registers, never combinationally from requester inputs.
  - Result: pmem strobes assert the cycle after the grant decision.
- D with both read and write asserted is executed as a write.
  - I reads drive pmem_wmask=2'b00.
- SERV_I / SERV_D: hold pmem_read or pmem_write and the latched fields constant until pmem_resp=1.
  - On pmem_resp: capture pmem_rdata into the winner's rdata register, deassert the pmem strobes next cycle, go to RESP.
  - No timeout.
- RESP: exactly one cycle.
  - Winner's resp=1 with rdata valid; the other resp=0.
  - Then go to IDLE.
  - Requests are not sampled in RESP. The requester must deassert, or present a new request, in the cycle after resp.
- Minimum turnaround: IDLE, grant, pmem strobe (≥1 cycle), RESP, IDLE. That is 4 cycles with zero-wait memory.
- Starvation counter (saturating, width ceil(log2(STARVE_MAX+1))):
  - Increments on each D grant while imem_read=1.
  - Clears on any I grant.
  - Clears on a D grant with imem_read=0.
- rdata registers hold their last value between responses.
- The pmem_resp input is ignored in IDLE and RESP.

Optional Feature:
- Macro: LC3B_ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant flop (reset = I, so D wins the first tie) flips on each grant. On simultaneous requests the requester not granted last wins. The starvation counter is not instantiated.
- Undefined: fixed D-priority with the starvation counter, as specified above.

Test Plan:
- Single I read, addr 0x3000, memory returns 0x1234 after 2 wait cycles → pmem_read high for 3 cycles with pmem_address=0x3000; imem_resp pulses once with imem_rdata=0x1234; dmem_resp stays 0.
- D write addr 0x4002, wdata 0xBEEF, wmask 2'b10 → pmem_write=1, pmem_wmask=2'b10, pmem_wdata=0xBEEF held until pmem_resp; dmem_resp one cycle; pmem_read never asserted.
- I and D request in the same cycle (fixed priority) → D served first, then I. Exactly two pmem transactions in that order, no overlap.
- D requests back-to-back continuously with I held, STARVE_MAX=4 → grants D,D,D,D,I. starve_cnt reads 0 after the I grant.
- rst_n pulled low mid-SERV_D with pmem_resp pending → pmem_read/pmem_write drop in the same cycle (asynchronously). No resp pulse. After release, a new I request completes normally.
- With LC3B_ARB_RR_EN defined, I and D held continuously → grants alternate D,I,D,I; each resp is a single-cycle pulse.
